noc_mining_ctrl: RTL

NOC_MINING_CTRL -- requirements
Module: noc_mining_ctrl

---
 rtl/noc_mining_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/noc_mining_ctrl.sv
// noc_mining_ctrl: broadcasts a mining job to every NoC worker under credit flow control, then collects results.
// Define NOC_MINING_CTRL_TIMEOUT_EN to add a result watchdog that ends the job after TIMEOUT_CYCLES idle cycles.
module noc_mining_ctrl #(
    parameter int FLIT_DATA_WIDTH = 64,
    parameter int NUM_VCS         = 2,
    parameter int NUM_DESTS       = 25,
    parameter int MSG_FLITS       = 10,
    parameter int BUF_DEPTH       = 16,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int FOUND_MSG       = 1,
    localparam int VCB = NUM_VCS > 1 ? $clog2(NUM_VCS) : 1,
    localparam int DB  = NUM_DESTS > 1 ? $clog2(NUM_DESTS) : 1,
    localparam int FW  = 2 + DB + VCB + FLIT_DATA_WIDTH
) (
    input  logic                                 CLK,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [MSG_FLITS*FLIT_DATA_WIDTH-1:0] msg_data,
    output logic [FW-1:0]                        putFlit,
    output logic                                 EN_putFlit,
    input  logic [VCB:0]                         getCredits,
    output logic                                 EN_getCredits,
    input  logic [FW-1:0]                        getFlit,
    output logic                                 EN_getFlit,
    output logic [VCB:0]                         putCredits,
    output logic                                 EN_putCredits,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 found,
    output logic [DB-1:0]                        found_src,
    output logic                                 credit_err,
    output logic                                 timeout
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int FB = MSG_FLITS > 1 ? $clog2(MSG_FLITS) : 1;
    localparam int NB = $clog2(NUM_DESTS + 1);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_RESULT, FINISH} state_t;
    state_t state_q;
    logic [FLIT_DATA_WIDTH-1:0] msg_q [MSG_FLITS];
    logic [FB-1:0] flit_q;
    logic [NB-1:0] dest_q, res_q;
    logic [CW-1:0] credit_q [NUM_VCS];
    logic [CW-1:0] credit_d [NUM_VCS];
    logic credit_err_q, err_d, en_put_flit_q, en_put_credits_q, en_get_credits_q, done_q, found_q;
    logic [FW-1:0] put_flit_q;
    logic [VCB:0] put_credits_q;
    logic [DB-1:0] found_src_q;
    logic [VCB-1:0] vc_c, res_vc, credit_vc;
    logic [DB-1:0] res_dest;
    logic tail_c, issue, res_valid, credit_ret, spare_unused;
    assign vc_c        = VCB'(32'(dest_q) % NUM_VCS);
    assign tail_c      = flit_q == FB'(MSG_FLITS - 1);
    assign issue       = state_q == SEND && dest_q != NB'(NUM_DESTS) && credit_q[vc_c] != '0;
    assign res_valid   = getFlit[FW-1];
    assign res_dest    = getFlit[FLIT_DATA_WIDTH+VCB +: DB];
    assign res_vc      = getFlit[FLIT_DATA_WIDTH +: VCB];
    assign credit_ret  = getCredits[VCB];
    assign credit_vc   = getCredits[VCB-1:0];
    assign spare_unused = getFlit[FW-2] ^ (TIMEOUT_CYCLES < 0);
    // A return and an issue on the same VC cancel out, even at the ceiling.
    always_comb begin
        credit_d = credit_q;
        err_d = credit_err_q;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (credit_ret && credit_vc == VCB'(v) && !(issue && vc_c == VCB'(v))) begin
                if (credit_q[v] == CW'(BUF_DEPTH)) err_d = 1'b1;
                else credit_d[v] = credit_q[v] + 1'b1;
            end else if (issue && vc_c == VCB'(v) && !(credit_ret && credit_vc == VCB'(v))) begin
                credit_d[v] = credit_q[v] - 1'b1;
            end
        end
    end
`ifdef NOC_MINING_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tcnt_q;
    logic timeout_q;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            for (int i = 0; i < MSG_FLITS; i++) msg_q[i] <= '0;
            flit_q <= '0;
            dest_q <= '0;
            res_q <= '0;
            for (int v = 0; v < NUM_VCS; v++) credit_q[v] <= CW'(BUF_DEPTH);
            credit_err_q <= 1'b0;
            put_flit_q <= '0;
            en_put_flit_q <= 1'b0;
            put_credits_q <= '0;
            en_put_credits_q <= 1'b0;
            en_get_credits_q <= 1'b0;
            done_q <= 1'b0;
            found_q <= 1'b0;
            found_src_q <= '0;
`ifdef NOC_MINING_CTRL_TIMEOUT_EN
            tcnt_q <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            credit_q <= credit_d;
            credit_err_q <= err_d;
            en_get_credits_q <= 1'b1;
            en_put_flit_q <= issue;
            if (issue) put_flit_q <= {1'b1, tail_c, DB'(dest_q), vc_c, msg_q[flit_q]};
            en_put_credits_q <= res_valid;
            put_credits_q <= res_valid ? {1'b1, res_vc} : '0;
            done_q <= 1'b0;
            found_q <= 1'b0;
`ifdef NOC_MINING_CTRL_TIMEOUT_EN
            timeout_q <= 1'b0;
            tcnt_q <= '0;
`endif
            case (state_q)
                IDLE: if (start) begin
                    for (int i = 0; i < MSG_FLITS; i++) msg_q[i] <= msg_data[i*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
                    flit_q <= '0;
                    dest_q <= '0;
                    res_q <= '0;
                    state_q <= SEND;
                end
                // The extra cycle at dest_q == NUM_DESTS lets the last flit drain before WAIT_RESULT.
                SEND: if (dest_q == NB'(NUM_DESTS)) state_q <= WAIT_RESULT;
                else if (issue) begin
                    flit_q <= tail_c ? '0 : flit_q + 1'b1;
                    if (tail_c) dest_q <= dest_q + 1'b1;
                end
                WAIT_RESULT: begin
                    if (res_valid) begin
                        res_q <= res_q + 1'b1;
                        if (getFlit[FLIT_DATA_WIDTH-1:0] == FLIT_DATA_WIDTH'(FOUND_MSG)) begin
                            found_q <= 1'b1;
                            found_src_q <= res_dest;
                            state_q <= FINISH;
                        end else if (res_q == NB'(NUM_DESTS - 1)) state_q <= FINISH;
                    end
`ifdef NOC_MINING_CTRL_TIMEOUT_EN
                    tcnt_q <= res_valid ? '0 : tcnt_q + 1'b1;
                    if (!res_valid && tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        state_q <= FINISH;
                    end
`endif
                end
                FINISH: begin
                    done_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign putFlit       = put_flit_q;
    assign EN_putFlit    = en_put_flit_q;
    assign EN_getCredits = en_get_credits_q;
    assign EN_getFlit    = state_q == WAIT_RESULT;
    assign putCredits    = put_credits_q;
    assign EN_putCredits = en_put_credits_q;
    assign busy          = state_q != IDLE;
    assign done          = done_q;
    assign found         = found_q;
    assign found_src     = found_src_q;
    assign credit_err    = credit_err_q;
endmodule
